// File: rtl/sfp_accum_if.sv
// Job control plus the psum input stream and activated output stream of sfp_accum.
interface sfp_accum_if #(
   parameter int psum_bw = 16,
   parameter int acc_bw  = 20,
   parameter int col     = 8,
   parameter int depth   = 16,
   parameter int pass_bw = 4
);
   logic                   start;
   logic [pass_bw-1:0]     num_pass;
   logic [$clog2(depth):0] num_rows;
   logic [1:0]             mode;
   logic                   in_valid;
   logic                   in_ready;
   logic [psum_bw*col-1:0] in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [acc_bw*col-1:0]  out_data;
   logic                   busy;
   logic                   done;

   modport master (
      output start, num_pass, num_rows, mode, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy, done
   );

   modport slave (
      input  start, num_pass, num_rows, mode, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, busy, done
   );
endinterface

// File: rtl/sfp_accum.sv
// Multi-pass per-row psum accumulator with saturating adds and an activation
// stage applied while draining the buffer over a valid/ready stream.
module sfp_accum #(
   parameter int psum_bw = 16,
   parameter int acc_bw  = 20,
   parameter int col     = 8,
   parameter int depth   = 16,
   parameter int pass_bw = 4
) (
   input logic        clk,
   input logic        reset,
   sfp_accum_if.slave bus
);
   localparam int rw = $clog2(depth);
   localparam int nw = rw + 1;
   localparam logic [acc_bw-1:0] acc_max = {1'b0, {(acc_bw-1){1'b1}}};
   localparam logic [acc_bw-1:0] acc_min = {1'b1, {(acc_bw-1){1'b0}}};
   localparam logic [acc_bw-1:0] acc_one = {{(acc_bw-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2} state_t;

   state_t                state_r;
   state_t                state_nxt_s;
   logic [rw-1:0]         row_ptr_r;
   logic [pass_bw-1:0]    pass_cnt_r;
   logic [nw-1:0]         rd_cnt_r;
   logic [pass_bw-1:0]    num_pass_r;
   logic [nw-1:0]         num_rows_r;
   logic [1:0]            mode_r;
   logic [acc_bw*col-1:0] acc_mem_r [depth];
   logic [acc_bw*col-1:0] out_data_r;
   logic                  out_valid_r;
   logic                  done_r;
   logic                  in_ready_s;
   logic                  busy_s;
   logic                  start_ok_s;
   logic                  xfer_s;
   logic                  row_last_s;
   logic                  pass_last_s;
   logic                  load_s;
   logic                  last_hs_s;
   logic [acc_bw*col-1:0] wr_row_s;
   logic [acc_bw*col-1:0] rd_row_s;

   function automatic logic [acc_bw-1:0] sign_ext(input logic [psum_bw-1:0] v);
      logic signed [psum_bw-1:0] s;
      logic signed [acc_bw-1:0]  r;
      s = v;
      r = acc_bw'(s);
      return r;
   endfunction

   function automatic logic [acc_bw-1:0] sat_add(input logic [acc_bw-1:0] a,
                                                 input logic [acc_bw-1:0] b);
      logic [acc_bw:0] sum;
      sum = {a[acc_bw-1], a} + {b[acc_bw-1], b};
      // Extra top bit disagreeing with the sign bit means the lane overflowed.
      if (sum[acc_bw] != sum[acc_bw-1]) begin
         return sum[acc_bw] ? acc_min : acc_max;
      end else begin
         return sum[acc_bw-1:0];
      end
   endfunction

   function automatic logic [acc_bw-1:0] activate(input logic [acc_bw-1:0] x,
                                                  input logic [1:0]        md);
      logic [acc_bw-1:0] r;
      case (md)
         2'b01: r = x[acc_bw-1] ? {acc_bw{1'b0}} : x;
         2'b10: begin
            if (x == acc_min) begin
               r = acc_max;
            end else if (x[acc_bw-1]) begin
               r = (~x) + acc_one;
            end else begin
               r = x;
            end
         end
         default: r = x;
      endcase
      return r;
   endfunction

   assign start_ok_s  = (state_r == IDLE) && bus.start &&
                        (bus.num_pass != {pass_bw{1'b0}}) &&
                        (bus.num_rows != {nw{1'b0}}) &&
                        (bus.num_rows <= nw'(depth));
   assign xfer_s      = bus.in_valid && in_ready_s;
   assign row_last_s  = ({1'b0, row_ptr_r} == (num_rows_r - nw'(1)));
   assign pass_last_s = (pass_cnt_r == (num_pass_r - pass_bw'(1)));
   assign load_s      = (state_r == DRAIN) && (!out_valid_r || bus.out_ready) &&
                        (rd_cnt_r < num_rows_r);
   assign last_hs_s   = (state_r == DRAIN) && out_valid_r && bus.out_ready &&
                        (rd_cnt_r == num_rows_r);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:    state_nxt_s = start_ok_s ? ACCUM : IDLE;
         ACCUM:   state_nxt_s = (xfer_s && row_last_s && pass_last_s) ? DRAIN : ACCUM;
         DRAIN:   state_nxt_s = last_hs_s ? IDLE : DRAIN;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      in_ready_s = 1'b0;
      busy_s     = 1'b0;
      case (state_r)
         ACCUM: begin
            in_ready_s = 1'b1;
            busy_s     = 1'b1;
         end
         DRAIN: begin
            in_ready_s = 1'b0;
            busy_s     = 1'b1;
         end
         default: begin
            in_ready_s = 1'b0;
            busy_s     = 1'b0;
         end
      endcase
   end

   // Job parameters, row/pass pointers and drain read pointer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_ptr_r  <= {rw{1'b0}};
         pass_cnt_r <= {pass_bw{1'b0}};
         rd_cnt_r   <= {nw{1'b0}};
         num_pass_r <= {pass_bw{1'b0}};
         num_rows_r <= {nw{1'b0}};
         mode_r     <= 2'b00;
      end else if (start_ok_s) begin
         num_pass_r <= bus.num_pass;
         num_rows_r <= bus.num_rows;
         mode_r     <= bus.mode;
         row_ptr_r  <= {rw{1'b0}};
         pass_cnt_r <= {pass_bw{1'b0}};
         rd_cnt_r   <= {nw{1'b0}};
      end else if (xfer_s) begin
         if (row_last_s) begin
            row_ptr_r  <= {rw{1'b0}};
            pass_cnt_r <= pass_cnt_r + pass_bw'(1);
         end else begin
            row_ptr_r  <= row_ptr_r + rw'(1);
         end
      end else if (load_s) begin
         rd_cnt_r <= rd_cnt_r + nw'(1);
      end
   end

   // New buffer row: pass 0 overwrites, later passes saturate-accumulate
   always_comb begin
      wr_row_s = acc_mem_r[row_ptr_r];
      for (int i = 0; i < col; i++) begin
         if (pass_cnt_r == {pass_bw{1'b0}}) begin
            wr_row_s[acc_bw*i +: acc_bw] = sign_ext(bus.in_data[psum_bw*i +: psum_bw]);
         end else begin
            wr_row_s[acc_bw*i +: acc_bw] = sat_add(acc_mem_r[row_ptr_r][acc_bw*i +: acc_bw],
                                                   sign_ext(bus.in_data[psum_bw*i +: psum_bw]));
         end
      end
   end

   // Accumulator buffer, left unreset since pass 0 always overwrites it
   always_ff @(posedge clk) begin
      if (xfer_s) begin
         acc_mem_r[row_ptr_r] <= wr_row_s;
      end
   end

   // Activated read of the row being drained
   always_comb begin
      rd_row_s = {(acc_bw*col){1'b0}};
      for (int i = 0; i < col; i++) begin
         rd_row_s[acc_bw*i +: acc_bw] = activate(acc_mem_r[rd_cnt_r[rw-1:0]][acc_bw*i +: acc_bw],
                                                 mode_r);
      end
   end

   // Output stage: holds under backpressure, pulses done after the last row
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_data_r  <= {(acc_bw*col){1'b0}};
         out_valid_r <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r <= last_hs_s;
         if (load_s) begin
            out_data_r  <= rd_row_s;
            out_valid_r <= 1'b1;
         end else if (last_hs_s) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.busy      = busy_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.done      = done_r;
endmodule

// File: tb/tb_sfp_accum.sv
// Directed bench for sfp_accum: a 20-bit-accumulator instance and a 16-bit one for saturation,
// checked every cycle against an integer reference model of accumulate/clamp/activate.
module tb_sfp_accum;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sfp_accum_if #(.psum_bw(16), .acc_bw(20), .col(8), .depth(16), .pass_bw(4)) ifa ();
   sfp_accum_if #(.psum_bw(16), .acc_bw(16), .col(2), .depth(4), .pass_bw(4)) ifb ();

   sfp_accum #(.psum_bw(16), .acc_bw(20), .col(8), .depth(16), .pass_bw(4)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa));
   sfp_accum #(.psum_bw(16), .acc_bw(16), .col(2), .depth(4), .pass_bw(4)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb));

   int vecs = 0;
   int errs = 0;
   int stim [0:3][0:15][0:7];
   logic [159:0] exp_a [$];
   logic [31:0]  exp_b [$];
   int hs_a = 0;
   int hs_b = 0;
   logic [159:0] last_a = '0;
   logic [31:0]  last_b = '0;

   task automatic chk(input bit ok, input string name, input logic [159:0] act,
                      input logic [159:0] req);
      vecs++;
      if (!ok) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic logic rd_busy(input int s);
      return (s == 0) ? ifa.busy : ifb.busy;
   endfunction
   function automatic logic rd_inr(input int s);
      return (s == 0) ? ifa.in_ready : ifb.in_ready;
   endfunction
   function automatic logic rd_done(input int s);
      return (s == 0) ? ifa.done : ifb.done;
   endfunction
   function automatic logic rd_ov(input int s);
      return (s == 0) ? ifa.out_valid : ifb.out_valid;
   endfunction

   task automatic clear_stim();
      for (int p = 0; p < 4; p++)
         for (int r = 0; r < 16; r++)
            for (int l = 0; l < 8; l++) stim[p][r][l] = 0;
   endtask

   task automatic drive_ctrl(input int s, input bit st, input int np, input int nr, input int md);
      if (s == 0) begin
         ifa.start = st; ifa.num_pass = np[3:0]; ifa.num_rows = nr[4:0]; ifa.mode = md[1:0];
      end else begin
         ifb.start = st; ifb.num_pass = np[3:0]; ifb.num_rows = nr[2:0]; ifb.mode = md[1:0];
      end
   endtask

   task automatic drive_data(input int s, input bit v, input int p, input int r);
      int t;
      if (s == 0) begin
         ifa.in_valid = v;
         for (int l = 0; l < 8; l++) begin
            t = stim[p][r][l];
            ifa.in_data[l*16 +: 16] = t[15:0];
         end
      end else begin
         ifb.in_valid = v;
         for (int l = 0; l < 2; l++) begin
            t = stim[p][r][l];
            ifb.in_data[l*16 +: 16] = t[15:0];
         end
      end
   endtask

   task automatic set_ready(input int s, input bit v);
      if (s == 0) ifa.out_ready = v; else ifb.out_ready = v;
   endtask

   // Reference: integer sums clamped after every pass, then activation, per lane.
   task automatic model_job(input int s, input int np, input int nr, input int md);
      longint hi, lo, acc;
      int ab, nc;
      logic [159:0] row;
      ab = (s == 0) ? 20 : 16;
      nc = (s == 0) ? 8 : 2;
      hi = (longint'(1) <<< (ab - 1)) - 1;
      lo = -(longint'(1) <<< (ab - 1));
      for (int r = 0; r < nr; r++) begin
         row = '0;
         for (int l = 0; l < nc; l++) begin
            acc = 0;
            for (int p = 0; p < np; p++) begin
               acc = (p == 0) ? longint'(stim[p][r][l]) : acc + longint'(stim[p][r][l]);
               if (acc > hi) acc = hi;
               if (acc < lo) acc = lo;
            end
            if (md == 1 && acc < 0) acc = 0;
            else if (md == 2 && acc < 0) acc = (-acc > hi) ? hi : -acc;
            if (s == 0) row[l*20 +: 20] = acc[19:0];
            else row[l*16 +: 16] = acc[15:0];
         end
         if (s == 0) exp_a.push_back(row);
         else exp_b.push_back(row[31:0]);
      end
   endtask

   task automatic run_job(input int s, input int np, input int nr, input int md,
                          input int stall_row, input int stall_n, input int abort_k,
                          input bit inject);
      int k, base, left;
      bit got;
      model_job(s, np, nr, md);
      base = (s == 0) ? hs_a : hs_b;
      left = stall_n;
      @(posedge clk); #1;
      drive_ctrl(s, 1'b1, np, nr, md);
      @(posedge clk); #1;
      drive_ctrl(s, 1'b0, np, nr, md);
      chk(rd_busy(s) && rd_inr(s), "accum_entry", 160'({rd_busy(s), rd_inr(s)}), 160'(2'b11));
      k = 0;
      for (int p = 0; p < np; p++) begin
         for (int r = 0; r < nr; r++) begin
            if (k == abort_k) begin
               reset = 1'b0;
               drive_data(s, 1'b0, 0, 0);
               #1;
               chk(!ifa.out_valid && !ifa.busy && !ifa.in_ready && !ifa.done && ifa.out_data == '0,
                   "abort_outputs", 160'({ifa.out_valid, ifa.busy, ifa.in_ready, ifa.done}), 160'(0));
               exp_a.delete();
               exp_b.delete();
               @(posedge clk); #1;
               reset = 1'b1;
               return;
            end
            chk(rd_inr(s), "in_ready_accum", 160'(rd_inr(s)), 160'(1));
            drive_data(s, 1'b1, p, r);
            if (inject && k == 1) drive_ctrl(s, 1'b1, 1, 1, 0);
            @(posedge clk); #1;
            drive_ctrl(s, 1'b0, np, nr, md);
            k++;
         end
      end
      drive_data(s, 1'b0, 0, 0);
      chk(!rd_inr(s) && rd_busy(s), "accum_exit", 160'({rd_inr(s), rd_busy(s)}), 160'(2'b01));
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
         @(posedge clk); #1;
         if (left > 0 && rd_ov(s) && (((s == 0) ? hs_a : hs_b) - base) == stall_row) begin
            set_ready(s, 1'b0);
            left--;
         end else begin
            set_ready(s, 1'b1);
         end
         if (rd_done(s)) got = 1'b1;
      end
      chk(got, "done_seen", 160'(got), 160'(1));
      chk(!rd_busy(s) && !rd_inr(s), "idle_after_done", 160'({rd_busy(s), rd_inr(s)}), 160'(0));
      chk(((s == 0) ? exp_a.size() : exp_b.size()) == 0, "rows_left",
          160'((s == 0) ? exp_a.size() : exp_b.size()), 160'(0));
      set_ready(s, 1'b1);
   endtask

   task automatic illegal_start(input int np, input int nr);
      @(posedge clk); #1;
      drive_ctrl(0, 1'b1, np, nr, 0);
      @(posedge clk); #1;
      drive_ctrl(0, 1'b0, 1, 1, 0);
      chk(!ifa.busy && !ifa.in_ready, "illegal_start_idle", 160'({ifa.busy, ifa.in_ready}), 160'(0));
      repeat (3) @(posedge clk);
      #1;
      chk(!ifa.busy, "illegal_start_stays", 160'(ifa.busy), 160'(0));
   endtask

   // Per-cycle compare of both instances: row data/order, hold under stall, done timing.
   initial begin
      bit done_pend_a = 1'b0, done_pend_b = 1'b0, hold_a = 1'b0, hold_b = 1'b0;
      logic [159:0] hold_data_a = '0, ea;
      logic [31:0]  hold_data_b = '0, eb;
      forever begin
         @(negedge clk);
         if (reset) begin
            chk(ifa.done == done_pend_a, "done_a", 160'(ifa.done), 160'(done_pend_a));
            chk(ifb.done == done_pend_b, "done_b", 160'(ifb.done), 160'(done_pend_b));
            done_pend_a = 1'b0;
            done_pend_b = 1'b0;
            if (hold_a) chk(ifa.out_valid && ifa.out_data == hold_data_a, "hold_a", ifa.out_data, hold_data_a);
            if (hold_b) chk(ifb.out_valid && ifb.out_data == hold_data_b, "hold_b", 160'(ifb.out_data), 160'(hold_data_b));
            if (ifa.out_valid && ifa.out_ready) begin
               if (exp_a.size() == 0) begin
                  chk(1'b0, "extra_row_a", ifa.out_data, 160'(0));
               end else begin
                  ea = exp_a.pop_front();
                  chk(ifa.out_data == ea, "row_a", ifa.out_data, ea);
                  last_a = ifa.out_data;
                  hs_a++;
                  if (exp_a.size() == 0) done_pend_a = 1'b1;
               end
            end
            if (ifb.out_valid && ifb.out_ready) begin
               if (exp_b.size() == 0) begin
                  chk(1'b0, "extra_row_b", 160'(ifb.out_data), 160'(0));
               end else begin
                  eb = exp_b.pop_front();
                  chk(ifb.out_data == eb, "row_b", 160'(ifb.out_data), 160'(eb));
                  last_b = ifb.out_data;
                  hs_b++;
                  if (exp_b.size() == 0) done_pend_b = 1'b1;
               end
            end
            hold_a = ifa.out_valid && !ifa.out_ready;
            hold_b = ifb.out_valid && !ifb.out_ready;
            hold_data_a = ifa.out_data;
            hold_data_b = ifb.out_data;
         end else begin
            done_pend_a = 1'b0; done_pend_b = 1'b0; hold_a = 1'b0; hold_b = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      drive_ctrl(0, 1'b0, 1, 1, 0);
      drive_ctrl(1, 1'b0, 1, 1, 0);
      drive_data(0, 1'b0, 0, 0);
      drive_data(1, 1'b0, 0, 0);
      ifa.out_ready = 1'b1;
      ifb.out_ready = 1'b1;
      clear_stim();
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk(!ifa.out_valid && !ifa.busy && !ifa.in_ready && !ifa.done && ifa.out_data == '0,
          "reset_a", ifa.out_data, 160'(0));
      chk(!ifb.out_valid && !ifb.busy && !ifb.in_ready && !ifb.done && ifb.out_data == '0,
          "reset_b", 160'(ifb.out_data), 160'(0));
      reset = 1'b1;

      // 1 pass, 2 rows, bypass
      clear_stim();
      stim[0][0][0] = 5; stim[0][1][0] = -3; stim[0][0][7] = -1; stim[0][1][3] = 1234;
      model_job(0, 1, 2, 0);
      chk(exp_a[0][19:0] == 20'd5, "pin_t1_r0", 160'(exp_a[0][19:0]), 160'(20'd5));
      chk(exp_a[1][19:0] == 20'hFFFFD, "pin_t1_r1", 160'(exp_a[1][19:0]), 160'(20'hFFFFD));
      chk(exp_a[0][159:140] == 20'hFFFFF, "pin_t1_l7", 160'(exp_a[0][159:140]), 160'(20'hFFFFF));
      exp_a.delete();
      run_job(0, 1, 2, 0, -1, 0, -1, 1'b0);
      chk(last_a[19:0] == 20'hFFFFD, "t1_last_row", 160'(last_a[19:0]), 160'(20'hFFFFD));

      // 3 passes, 1 row, ReLU
      clear_stim();
      stim[0][0][0] = -4; stim[1][0][0] = -4; stim[2][0][0] = 3;
      stim[0][0][1] = 2;  stim[1][0][1] = 2;  stim[2][0][1] = 2;
      model_job(0, 3, 1, 1);
      chk(exp_a[0][39:0] == {20'd6, 20'd0}, "pin_t2", 160'(exp_a[0][39:0]), 160'({20'd6, 20'd0}));
      exp_a.delete();
      run_job(0, 3, 1, 1, -1, 0, -1, 1'b0);
      chk(last_a[39:0] == {20'd6, 20'd0}, "t2_row", 160'(last_a[39:0]), 160'({20'd6, 20'd0}));

      // 2 passes, 3 rows, abs, row 1 stalled for 5 cycles
      clear_stim();
      for (int p = 0; p < 2; p++)
         for (int r = 0; r < 3; r++)
            for (int l = 0; l < 8; l++) stim[p][r][l] = (l - 3) * 1000 + r * 17 + p * 5;
      model_job(0, 2, 3, 2);
      chk(exp_a[0][19:0] == 20'd5995, "pin_t3", 160'(exp_a[0][19:0]), 160'(20'd5995));
      exp_a.delete();
      run_job(0, 2, 3, 2, 1, 5, -1, 1'b0);

      // mode 11 as bypass, full depth, start pulse mid-job must be ignored
      clear_stim();
      for (int p = 0; p < 2; p++)
         for (int r = 0; r < 16; r++)
            for (int l = 0; l < 8; l++) stim[p][r][l] = -(r * 256 + l) - p * 4096;
      model_job(0, 2, 16, 3);
      chk(exp_a[15][159:140] == 20'hFD1F2, "pin_t4", 160'(exp_a[15][159:140]), 160'(20'hFD1F2));
      exp_a.delete();
      run_job(0, 2, 16, 3, -1, 0, -1, 1'b1);

      // acc_bw == psum_bw saturation
      clear_stim();
      stim[0][0][0] = 28672; stim[1][0][0] = 28672; stim[0][0][1] = -32768; stim[1][0][1] = -32768;
      model_job(1, 2, 1, 0);
      chk(exp_b[0] == {16'h8000, 16'h7FFF}, "pin_sat_add", 160'(exp_b[0]), 160'({16'h8000, 16'h7FFF}));
      exp_b.delete();
      run_job(1, 2, 1, 0, -1, 0, -1, 1'b0);
      chk(last_b == {16'h8000, 16'h7FFF}, "sat_add_row", 160'(last_b), 160'({16'h8000, 16'h7FFF}));
      clear_stim();
      stim[0][0][0] = -32768; stim[0][0][1] = -5;
      run_job(1, 1, 1, 2, -1, 0, -1, 1'b0);
      chk(last_b == {16'd5, 16'h7FFF}, "abs_min_row", 160'(last_b), 160'({16'd5, 16'h7FFF}));
      clear_stim();
      stim[0][0][0] = -32768; stim[1][0][0] = -32768; stim[0][0][1] = 28672; stim[1][0][1] = 28672;
      run_job(1, 2, 1, 1, -1, 0, -1, 1'b0);
      chk(last_b == {16'h7FFF, 16'h0000}, "relu_sat_row", 160'(last_b), 160'({16'h7FFF, 16'h0000}));

      // illegal starts
      illegal_start(1, 0);
      illegal_start(0, 2);
      illegal_start(1, 17);

      // reset during pass 2, then a clean single-pass job
      clear_stim();
      for (int p = 0; p < 3; p++)
         for (int r = 0; r < 4; r++)
            for (int l = 0; l < 8; l++) stim[p][r][l] = 1000 + r * 10 + l;
      run_job(0, 3, 4, 0, -1, 0, 6, 1'b0);
      clear_stim();
      for (int r = 0; r < 4; r++)
         for (int l = 0; l < 8; l++) stim[0][r][l] = 7 * r - l;
      run_job(0, 1, 4, 0, -1, 0, -1, 1'b0);
      chk(last_a[19:0] == 20'd21, "post_abort_row", 160'(last_a[19:0]), 160'(20'd21));

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
